// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first,
// using a single full-subtractor cell and a borrow flop behind a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] areg, breg, res;
    logic [CW-1:0]    count;
    logic             bw;

    logic             a_i, b_i, d, bw_nxt, last;
    logic [WIDTH-1:0] res_nxt;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    always_comb begin
        a_i     = areg[0];
        b_i     = breg[0];
        d       = a_i ^ b_i ^ bw;
        bw_nxt  = (~a_i & b_i) | (~(a_i ^ b_i) & bw);
        res_nxt = {d, res[WIDTH-1:1]};
        last    = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Visible diff/borrow_out load only on the final bit so they hold steady during SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            areg       <= '0;
            breg       <= '0;
            res        <= '0;
            count      <= '0;
            bw         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        areg  <= a;
                        breg  <= b;
                        res   <= '0;
                        count <= '0;
                        bw    <= 1'b0;
                    end
                end
                SHIFT: begin
                    areg  <= {1'b0, areg[WIDTH-1:1]};
                    breg  <= {1'b0, breg[WIDTH-1:1]};
                    res   <= res_nxt;
                    bw    <= bw_nxt;
                    count <= count + CW'(1);
                    if (last) begin
                        diff       <= res_nxt;
                        borrow_out <= bw_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor: 8-bit vectors plus a 4-bit exhaustive sweep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, borrow_out;
    logic [7:0] diff;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done4  = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
    );

    always @(negedge clk) begin
        if (done4) n_done4++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Launch one 8-bit op; returns at the negedge where done is seen.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tbv, output int cyc, output int bcyc);
        @(negedge clk);
        a = ta; b = tbv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tbv;
        cyc = 1; bcyc = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) bcyc++;
        end
        if (!done) check("timeout8", 0, 1);
    endtask

    task automatic run4(input logic [3:0] ta, input logic [3:0] tbv, output int cyc);
        @(negedge clk);
        a4 = ta; b4 = tbv; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 1;
        while (!done4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!done4) check("timeout4", 0, 1);
    endtask

    initial begin
        int cyc, bcyc, t, first_t, second_t, pulses;
        logic [7:0] first_d, second_d;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        check("rst_busy4", busy4, 0);
        rst = 1'b0;

        // 200 - 55
        run8(8'd200, 8'd55, cyc, bcyc);
        check("t1_latency", cyc, 9);
        check("t1_busy_cycles", bcyc, 8);
        check("t1_diff", diff, 145);
        check("t1_borrow", borrow_out, 0);
        check("t1_done_busy", busy, 0);
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_diff_hold", diff, 145);

        run8(8'd5, 8'd10, cyc, bcyc);
        check("t2_diff", diff, 8'hFB);
        check("t2_borrow", borrow_out, 1);

        run8(8'hA5, 8'hA5, cyc, bcyc);
        check("t3a_diff", diff, 0);
        check("t3a_borrow", borrow_out, 0);
        run8(8'd0, 8'd255, cyc, bcyc);
        check("t3b_diff", diff, 1);
        check("t3b_borrow", borrow_out, 1);
        run8(8'd128, 8'd1, cyc, bcyc);
        check("t3c_diff", diff, 127);
        check("t3c_borrow", borrow_out, 0);

        // start held high; a changes mid-op
        @(negedge clk);
        a = 8'd9; b = 8'd3; start = 1'b1;
        t = 0; first_t = 0; second_t = 0; first_d = '0; second_d = '0;
        while (second_t == 0 && t < 40) begin
            @(negedge clk);
            t++;
            if (t == 3) a = 8'd100;
            if (t == 15) check("t4_diff_hold_shift", diff, 6);
            if (done) begin
                if (first_t == 0) begin first_t = t; first_d = diff; end
                else begin second_t = t; second_d = diff; end
            end
        end
        start = 1'b0;
        check("t4_first_t", first_t, 9);
        check("t4_first_diff", first_d, 6);
        check("t4_second_t", second_t, 19);
        check("t4_second_diff", second_d, 97);

        // reset at 4th SHIFT cycle
        @(negedge clk);
        a = 8'd200; b = 8'd55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_diff", diff, 0);
        check("t5_borrow", borrow_out, 0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("t5_no_done", pulses, 0);
        run8(8'd20, 8'd7, cyc, bcyc);
        check("t5_diff_after", diff, 13);
        check("t5_borrow_after", borrow_out, 0);

        // rst and start together
        @(negedge clk);
        a = 8'd50; b = 8'd1; rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rs_busy", busy, 0);
        @(negedge clk);
        check("rs_busy_next", busy, 0);
        check("rs_diff", diff, 0);

        // exhaustive 4-bit sweep
        n_done4 = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run4(4'(ia), 4'(ib), cyc);
                if (ia == 0 && ib == 0) check("w4_latency", cyc, 5);
                check($sformatf("w4_%0d_%0d", ia, ib), {27'd0, borrow4, diff4},
                      {27'd0, (ia < ib) ? 1'b1 : 1'b0, 4'((ia - ib) & 15)});
            end
        end
        @(negedge clk);
        check("w4_done_count", n_done4, 256);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
